// File: rtl/sram_1rw_wmask_init_if.sv
// Access bus for the single-port masked-write SRAM with self-clearing sweep.
// The master drives commands; the slave (memory) returns read data, read strobe and busy.
interface sram_1rw_wmask_init_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 64
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic                  clr0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  rvalid0;
  logic                  busy0;

  modport master (
    output csb0, web0, wmask0, addr0, din0, clr0,
    input  dout0, rvalid0, busy0
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, clr0,
    output dout0, rvalid0, busy0
  );
endinterface

// File: rtl/sram_1rw_wmask_init.sv
// Single-port SRAM with per-lane write mask, registered read data and a
// zeroing sweep that runs after reset and on request.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | sweeping: one zero word per cycle at r_clr_ptr, access ignored
// ST_READY | normal operation: reads/writes accepted, clr0 starts a sweep
module sram_1rw_wmask_init #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 64,
  parameter int VERBOSE     = 0
) (
  input  logic                    clk0,
  input  logic                    rst_aL,
  sram_1rw_wmask_init_if.slave    bus
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_lanes
    $error("sram_1rw_wmask_init: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if ((VERBOSE != 0) && (VERBOSE != 1)) begin : g_bad_verbose
    $error("sram_1rw_wmask_init: VERBOSE must be 0 or 1");
  end

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_ready;
  logic w_acc;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_sweep_we;
  logic w_sweep_last;

  // clr0 has priority over any access presented in the same cycle
  assign w_ready      = (r_state == ST_READY);
  assign w_acc        = w_ready && !bus.csb0 && !bus.clr0;
  assign w_rd_acc     = w_acc && bus.web0;
  assign w_wr_acc     = w_acc && !bus.web0;
  assign w_sweep_we   = (r_state == ST_INIT);
  assign w_sweep_last = (r_clr_ptr == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk0 or negedge rst_aL) begin
    if (!rst_aL) begin
      r_state   <= ST_INIT;
      r_clr_ptr <= '0;
      r_dout    <= '0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[bus.addr0];
      end
      case (r_state)
        ST_INIT: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (w_sweep_last) begin
            r_state <= ST_READY;
          end
        end
        ST_READY: begin
          if (bus.clr0) begin
            r_state   <= ST_INIT;
            r_clr_ptr <= '0;
          end
        end
        default: begin
          r_state   <= ST_INIT;
          r_clr_ptr <= '0;
        end
      endcase
    end
  end

  // The array itself has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk0) begin
    if (w_sweep_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr_acc) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (bus.wmask0[i]) begin
          r_mem[bus.addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
        end
      end
    end
  end

  assign bus.dout0   = r_dout;
  assign bus.rvalid0 = r_rvalid;
  assign bus.busy0   = (r_state == ST_INIT);
endmodule

// File: doc/sram_1rw_wmask_init.md
SRAM_1RW_WMASK_INIT -- requirements
Module: sram_1rw_wmask_init

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width; depth = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter WMASK_WIDTH, default 64, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_WIDTH (derived).
REQ-004 SHALL have parameter VERBOSE, default 0, enabling $display of each accepted read/write (simulation only).
REQ-005 clk0  input  1  clock; all state changes on rising edge only.
REQ-006 rst_aL  input  1  reset; asynchronous, active-low.
REQ-007 csb0  input  1  active-low chip select.
REQ-008 web0  input  1  active-low write enable (1 = read).
REQ-009 wmask0  input  NUM_WMASKS  per-lane write enable.
REQ-010 addr0  input  ADDR_WIDTH  word address.
REQ-011 din0  input  DATA_WIDTH  write data.
REQ-012 clr0  input  1  synchronous request to zero the whole array.
REQ-013 dout0  output  DATA_WIDTH  registered read data.
REQ-014 rvalid0  output  1  one-cycle pulse, dout0 updated by a read.
REQ-015 busy0  output  1  high while array is being cleared; accesses ignored.

Function
REQ-016 SHALL be a two-state FSM: INIT (clearing) and READY.
REQ-017 INIT: each cycle write all-zero word at clr_ptr, increment clr_ptr; when clr_ptr = 2^ADDR_WIDTH-1 is written, go to READY next edge; clearing takes exactly 2^ADDR_WIDTH cycles.
REQ-018 busy0 SHALL equal (state == INIT), combinationally from state.
REQ-019 READY with clr0=1: go to INIT, clr_ptr=0; any access that same cycle SHALL be ignored.
REQ-020 clr0 while in INIT SHALL be ignored (sweep not restarted).
REQ-021 Access accepted only when state=READY, csb0=0, clr0=0; otherwise no memory change, rvalid0=0, dout0 held.
REQ-022 Read (web0=1): dout0 <= mem[addr0] at the accepting edge; rvalid0=1 for exactly the following cycle; latency 1 cycle.
REQ-023 Write (web0=0): for each lane i with wmask0[i]=1, mem[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= same slice of din0; unmasked lanes unchanged.
REQ-024 Write with wmask0 all zero SHALL be a legal no-op.
REQ-025 Writes SHALL not change dout0 or raise rvalid0.
REQ-026 Read in cycle N+1 of address written in cycle N SHALL return the newly written data.
REQ-027 dout0 SHALL hold its last read value indefinitely between reads, including across a clr0 sweep.
REQ-028 Addresses are full range; no out-of-range case exists; clr_ptr wraps only via REQ-017 exit.
REQ-029 Synthesis SHALL tolerate DATA_WIDTH not a multiple of WMASK_WIDTH only by $error at elaboration (illegal configuration).

Reset
REQ-030 rst_aL=0 SHALL immediately force state=INIT, clr_ptr=0, dout0=0, rvalid0=0 (busy0=1).
REQ-031 Memory array SHALL not be reset directly; it is zeroed by the INIT sweep after rst_aL rises.
REQ-032 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0; pending rvalid0 dropped.

Verification
REQ-033 Release reset, hold csb0=0 reads -> busy0=1 for 64 cycles, rvalid0=0 throughout; first read of any addr after busy0 falls returns 0, rvalid0 one cycle later.
REQ-034 Write addr 5 din=0xAAAA..._5555... wmask=2'b01, then write addr 5 din=0xFFFF..._0000... wmask=2'b10, read addr 5 -> dout0=0xFFFF...FFFF_5555...5555 upper/lower lanes respectively.
REQ-035 Write addr 63 = 0x1234, next cycle read addr 63 -> dout0=0x1234 with rvalid0=1 the cycle after.
REQ-036 Fill mem, read addr 3 (value X), assert clr0 one cycle -> busy0=1 64 cycles, dout0 stays X, then read addr 3 -> 0.
REQ-037 Assert rst_aL low asynchronously between edges during sweep at clr_ptr=20 -> dout0=0, busy0=1 immediately; after release sweep lasts full 64 cycles.
REQ-038 Parametrise DATA_WIDTH=32, ADDR_WIDTH=4, WMASK_WIDTH=8: byte-lane write wmask=4'b0100 to addr 15 changes bits [23:16] only; sweep lasts 16 cycles.
